// File: rtl/loopback_seq.sv
// loopback_seq: drives an 18-entry pattern set onto a pad loopback path and checks what returns
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start, abort         begin a run (idle only) / end a run early (while busy)
//   exp_mask, ret_in     per-bit compare enable and returned loopback data
//   pat_out, pat_oe      driven pattern and its output enable
//   busy, done, pass     run in progress, end-of-run pulse, result of last completed run
//   err_cnt, first_fail  saturating failing-check count, index of first failure (31 = none)
module loopback_seq #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] exp_mask,
   input  logic [7:0] ret_in,
   output logic [7:0] pat_out,
   output logic [7:0] pat_oe,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_cnt,
   output logic [4:0] first_fail
);
   typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;
   localparam logic [7:0] CNT_INIT = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;
   localparam logic [4:0] NONE = 5'd31;
   localparam logic [4:0] LAST = 5'd17;
   state_t     state_q;
   logic [4:0] idx_q;
   logic [7:0] cnt_q;
   logic [7:0] pat_out_q;
   logic [7:0] pat_oe_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [7:0] err_cnt_q;
   logic [4:0] first_fail_q;
   logic       err_hit;
   logic [7:0] err_cnt_d;
   logic [4:0] first_fail_d;
   logic [4:0] idx_d;
   function automatic logic [7:0] pattern(input logic [4:0] i);
      return (i == 5'd0) ? 8'h00 :
             (i == 5'd1) ? 8'hFF :
             (i < 5'd10) ? 8'h01 << (i - 5'd2) :
                           ~(8'h01 << (i - 5'd10));
   endfunction
   // pat_out_q holds pattern[idx_q] for the whole DRIVE/SETTLE/CHECK span
   always_comb begin
      err_hit      = (state_q == S_CHECK) && |((ret_in ^ pat_out_q) & exp_mask);
      err_cnt_d    = (err_hit && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
      first_fail_d = (err_hit && first_fail_q == NONE) ? idx_q : first_fail_q;
      idx_d        = idx_q + 5'd1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= 5'd0;
         cnt_q        <= 8'd0;
         pat_out_q    <= 8'h00;
         pat_oe_q     <= 8'h00;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_cnt_q    <= 8'd0;
         first_fail_q <= NONE;
      end else begin
         // the CHECK compare lands even when an abort arrives in the same cycle
         err_cnt_q    <= err_cnt_d;
         first_fail_q <= first_fail_d;
         done_q       <= 1'b0;
         if (abort && busy_q) begin
            state_q   <= S_IDLE;
            idx_q     <= 5'd0;
            pat_out_q <= 8'h00;
            pat_oe_q  <= 8'h00;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     state_q      <= S_DRIVE;
                     idx_q        <= 5'd0;
                     pat_out_q    <= pattern(5'd0);
                     pat_oe_q     <= 8'hFF;
                     busy_q       <= 1'b1;
                     pass_q       <= 1'b0;
                     err_cnt_q    <= 8'd0;
                     first_fail_q <= NONE;
                  end
               end
               S_DRIVE: begin
                  state_q <= (SETTLE == 0) ? S_CHECK : S_SETTLE;
                  cnt_q   <= CNT_INIT;
               end
               S_SETTLE: begin
                  if (cnt_q == 8'd0) state_q <= S_CHECK;
                  else cnt_q <= cnt_q - 8'd1;
               end
               S_CHECK: begin
                  if (idx_q == LAST) begin
                     state_q   <= S_DONE;
                     idx_q     <= 5'd0;
                     pat_out_q <= 8'h00;
                     pat_oe_q  <= 8'h00;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     pass_q    <= (err_cnt_d == 8'd0);
                  end else begin
                     state_q   <= S_DRIVE;
                     idx_q     <= idx_d;
                     pat_out_q <= pattern(idx_d);
                  end
               end
               S_DONE: state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end
   assign pat_out    = pat_out_q;
   assign pat_oe     = pat_oe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_cnt    = err_cnt_q;
   assign first_fail = first_fail_q;
endmodule

// File: tb/tb_loopback_seq.sv
// tb_loopback_seq: self-checking bench for loopback_seq with SETTLE=2 and SETTLE=0 instances
module tb_loopback_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic sel = 1'b1;
   logic [7:0] exp_mask = 8'hFF;
   logic [7:0] xm = 8'h00, am = 8'hFF, om = 8'h00;
   logic [7:0] dly2 = 8'h00;
   logic [7:0] pat2, oe2, err2, pat0, oe0, err0, ret2, ret0;
   logic busy2, done2, pass2, busy0, done0, pass0;
   logic [4:0] ff2, ff0;
   logic [7:0] pat_out, pat_oe, err_cnt;
   logic busy, done, pass;
   logic [4:0] first_fail;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // return path fault model: invert xm bits, force-0 where am is 0, force-1 where om is 1
   always @(posedge clk) dly2 <= pat2;
   assign ret2 = ((dly2 ^ xm) & am) | om;
   assign ret0 = ((pat0 ^ xm) & am) | om;

   loopback_seq #(.SETTLE(2)) u2 (
      .clk(clk), .rst(rst), .start(start & sel), .abort(abort), .exp_mask(exp_mask), .ret_in(ret2),
      .pat_out(pat2), .pat_oe(oe2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_fail(ff2));
   loopback_seq #(.SETTLE(0)) u0 (
      .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort), .exp_mask(exp_mask), .ret_in(ret0),
      .pat_out(pat0), .pat_oe(oe0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .first_fail(ff0));

   assign pat_out    = sel ? pat2 : pat0;
   assign pat_oe     = sel ? oe2 : oe0;
   assign busy       = sel ? busy2 : busy0;
   assign done       = sel ? done2 : done0;
   assign pass       = sel ? pass2 : pass0;
   assign err_cnt    = sel ? err2 : err0;
   assign first_fail = sel ? ff2 : ff0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int k);
      logic [7:0] one;
      one = 8'h01;
      if (k == 0) return 8'h00;
      if (k == 1) return 8'hFF;
      if (k < 10) return one << (k - 2);
      return ~(one << (k - 10));
   endfunction

   // expected result of checking patterns 0..n-1 through the current fault model and mask
   task automatic model(input int n, output int e, output int f);
      logic [7:0] p, r;
      e = 0;
      f = 31;
      for (int k = 0; k < n; k++) begin
         p = pat(k);
         r = ((p ^ xm) & am) | om;
         if (((r ^ p) & exp_mask) != 8'h00) begin
            e++;
            if (f == 31) f = k;
         end
      end
   endtask

   task automatic setm(input logic [7:0] x, input logic [7:0] a, input logic [7:0] o, input logic [7:0] m);
      xm = x; am = a; om = o; exp_mask = m;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "/pat_out"}, int'(pat_out), 0);
      chk({tag, "/pat_oe"}, int'(pat_oe), 0);
      chk({tag, "/busy"}, int'(busy), 0);
      chk({tag, "/done"}, int'(done), 0);
      chk({tag, "/pass"}, int'(pass), 0);
      chk({tag, "/err_cnt"}, int'(err_cnt), 0);
      chk({tag, "/first_fail"}, int'(first_fail), 31);
   endtask

   task automatic go(input bit s);
      sel = s;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // full run; poke>0 pulses start during that busy cycle, which must change nothing
   task automatic run(input bit s, input int poke, input int e, input int f, input int p, input string tag);
      int per, dc, bc, bad;
      per = s ? 4 : 2;
      dc = -1;
      bc = 0;
      bad = 0;
      go(s);
      for (int c = 1; c <= 200 && dc < 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk({tag, "/clr_err"}, int'(err_cnt), 0);
            chk({tag, "/clr_ff"}, int'(first_fail), 31);
         end
         if (busy) bc++;
         if (done) begin
            dc = c;
            chk({tag, "/done_oe"}, int'(pat_oe), 0);
         end
         if (c % per == 1 && c <= 1 + 17 * per && !(pat_out == pat((c - 1) / per) && pat_oe == 8'hFF)) bad++;
         start = (c == poke);
      end
      start = 1'b0;
      chk({tag, "/done_cycle"}, dc, 18 * per + 1);
      chk({tag, "/busy_cycles"}, bc, 18 * per);
      chk({tag, "/pattern_seq_errs"}, bad, 0);
      chk({tag, "/err_cnt"}, int'(err_cnt), e);
      chk({tag, "/first_fail"}, int'(first_fail), f);
      chk({tag, "/pass"}, int'(pass), p);
   endtask

   typedef struct {
      bit s;
      logic [7:0] x, a, o, m;
      int e, f, p;
   } vec_t;
   vec_t tbl[10];

   initial begin
      int e, f, dn;
      tbl[0] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0, 31, 1};
      tbl[1] = '{1'b1, 8'h00, 8'hF7, 8'h00, 8'hFF, 9, 1, 0};
      tbl[2] = '{1'b1, 8'h00, 8'hF7, 8'h00, 8'hF7, 0, 31, 1};
      tbl[3] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 0, 31, 1};
      tbl[4] = '{1'b1, 8'h00, 8'hFF, 8'h01, 8'hFF, 9, 0, 0};
      tbl[5] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF, 18, 0, 0};
      tbl[6] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF, 18, 0, 0};
      tbl[7] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF, 18, 0, 0};
      tbl[8] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 18, 0, 0};
      tbl[9] = '{1'b0, 8'h00, 8'hF7, 8'h00, 8'hFF, 9, 1, 0};
      repeat (3) @(negedge clk);
      chk_rst("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_rst("idle");
      for (int i = 0; i < 10; i++) begin
         setm(tbl[i].x, tbl[i].a, tbl[i].o, tbl[i].m);
         run(tbl[i].s, 10, tbl[i].e, tbl[i].f, tbl[i].p, $sformatf("vec%0d", i));
      end
      repeat (3) @(negedge clk);
      chk("pass_hold", int'(pass), 0);
      setm(8'h00, 8'hFF, 8'h00, 8'hFF);
      run(1'b1, 0, 0, 31, 1, "perfect2");
      repeat (3) @(negedge clk);
      chk("pass_hold1", int'(pass), 1);
      // abort in SETTLE of pattern 5 (SETTLE=2: DRIVE at 21, SETTLE at 22..23)
      setm(8'h00, 8'hFF, 8'h01, 8'hFF);
      go(1'b1);
      repeat (22) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      model(5, e, f);
      chk("abort/busy", int'(busy), 0);
      chk("abort/pat_oe", int'(pat_oe), 0);
      chk("abort/pat_out", int'(pat_out), 0);
      chk("abort/pass", int'(pass), 0);
      chk("abort/err_cnt", int'(err_cnt), e);
      chk("abort/first_fail", int'(first_fail), f);
      dn = 0;
      repeat (80) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("abort/no_done", dn, 0);
      // abort in the CHECK of pattern 0 (cycle 4) still counts that compare
      go(1'b1);
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_chk/busy", int'(busy), 0);
      chk("abort_chk/err_cnt", int'(err_cnt), 1);
      chk("abort_chk/first_fail", int'(first_fail), 0);
      setm(8'h00, 8'hFF, 8'h00, 8'hFF);
      run(1'b1, 0, 0, 31, 1, "after_abort");
      // reset in the CHECK of pattern 10 (cycle 44), start held high during reset
      setm(8'h00, 8'hFF, 8'h01, 8'hFF);
      go(1'b1);
      repeat (44) @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk_rst("midrst");
      @(negedge clk);
      chk("midrst/start_ignored", int'(busy), 0);
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("midrst/still_idle", int'(busy), 0);
      setm(8'h00, 8'hFF, 8'h00, 8'hFF);
      run(1'b0, 7, 0, 31, 1, "after_rst");
      // randomized fault models and masks against the reference model
      for (int i = 0; i < 12; i++) begin
         setm(8'($urandom & $urandom & $urandom), 8'($urandom | $urandom | $urandom),
              8'($urandom & $urandom & $urandom), 8'($urandom | $urandom));
         model(18, e, f);
         run(1'($urandom_range(0, 1)), 0, e, f, (e == 0) ? 1 : 0, $sformatf("rnd%0d", i));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
